// File: rtl/packet_framer.sv
// -----------------------------------------------------------------------------
// packet_framer
//
// Pulls fixed-width sample words from the upstream ring buffer's read port and
// emits them as framed byte packets on a valid/ready byte stream:
//
//   SYNC_BYTE | seq | PACKET_WORDS x WORD_BYTES payload bytes (MSB first) | check
//
// The check byte covers the sequence byte and all payload bytes, but not the
// sync byte.
//
// Build option:
//   PACKET_FRAMER_CRC_EN  defined   -> check byte is CRC-8, poly 0x07, init 0x00,
//                                      MSB first, no reflection, no final XOR
//                         undefined -> check byte is the 8-bit sum (mod 256)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous, active-low reset
//   in_empty   in   ring buffer empty flag (registered upstream)
//   in_data    in   ring buffer head word, valid while in_empty = 0
//   in_pop     out  consume the head word this cycle
//   out_valid  out  out_data holds a byte
//   out_ready  in   downstream accepts the byte
//   out_data   out  stream byte
//   out_last   out  high with the check byte
//   seq        out  sequence number of the current/next packet
//
// All outputs are decoded from registered state only (plus in_empty for
// in_pop, which is itself registered upstream), so there is no combinational
// path from out_ready to any output.
// -----------------------------------------------------------------------------
module packet_framer #(
  parameter int         WORD_BYTES   = 2,
  parameter int         PACKET_WORDS = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_empty,
  input  logic [8*WORD_BYTES-1:0] in_data,
  output logic                    in_pop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic                    out_last,
  output logic [7:0]              seq
);

  localparam int DW  = 8 * WORD_BYTES;
  localparam int BCW = $clog2(WORD_BYTES) + 1;

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(WORD_BYTES - 1);
  localparam logic [7:0]     LAST_WORD = 8'(PACKET_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    SEQ     = 3'd2,
    LOAD    = 3'd3,
    PAYLOAD = 3'd4,
    CHECK   = 3'd5
  } state_t;

  // Fold one byte into the running check value.
  function automatic logic [7:0] check_update(input logic [7:0] acc,
                                              input logic [7:0] data);
`ifdef PACKET_FRAMER_CRC_EN
    logic [7:0] c;
    c = acc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ 8'h07;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
`else
    return 8'(acc + data);
`endif
  endfunction

  state_t          state_r;
  state_t          state_next_s;
  logic [DW-1:0]   shift_r;
  logic [BCW-1:0]  byte_cnt_r;
  logic [7:0]      word_cnt_r;
  logic [7:0]      acc_r;
  logic [7:0]      seq_r;
  logic [7:0]      head_byte_s;
  logic            handshake_s;

  assign head_byte_s = shift_r[DW-1 -: 8];
  assign seq         = seq_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and output decode from the registered state.
  always_comb begin
    state_next_s = state_r;
    out_valid    = 1'b0;
    out_data     = 8'h00;
    out_last     = 1'b0;
    in_pop       = 1'b0;

    case (state_r)
      IDLE: begin
        // A header is only started once there is a word to follow it.
        if (!in_empty) begin
          state_next_s = SYNC;
        end else begin
          state_next_s = IDLE;
        end
      end

      SYNC: begin
        out_valid = 1'b1;
        out_data  = SYNC_BYTE;
        if (out_ready) begin
          state_next_s = SEQ;
        end else begin
          state_next_s = SYNC;
        end
      end

      SEQ: begin
        out_valid = 1'b1;
        out_data  = seq_r;
        if (out_ready) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = SEQ;
        end
      end

      LOAD: begin
        // Bubble cycle: fetch the next word, stall here while upstream is dry.
        in_pop = !in_empty;
        if (!in_empty) begin
          state_next_s = PAYLOAD;
        end else begin
          state_next_s = LOAD;
        end
      end

      PAYLOAD: begin
        out_valid = 1'b1;
        out_data  = head_byte_s;
        if (out_ready && (byte_cnt_r == LAST_BYTE)) begin
          // word_cnt_r already counts the word currently being shifted out.
          if (word_cnt_r < LAST_WORD) begin
            state_next_s = LOAD;
          end else begin
            state_next_s = CHECK;
          end
        end else begin
          state_next_s = PAYLOAD;
        end
      end

      CHECK: begin
        out_valid = 1'b1;
        out_data  = acc_r;
        out_last  = 1'b1;
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = CHECK;
        end
      end

      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign handshake_s = out_valid && out_ready;

  // Datapath: shift register, counters, check accumulator and sequence number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r    <= '0;
      byte_cnt_r <= '0;
      word_cnt_r <= 8'h00;
      acc_r      <= 8'h00;
      seq_r      <= 8'h00;
    end else begin
      case (state_r)
        SYNC: begin
          // The sync byte is not covered by the check byte.
          acc_r      <= 8'h00;
          word_cnt_r <= 8'h00;
        end

        SEQ: begin
          if (handshake_s) begin
            acc_r <= check_update(acc_r, seq_r);
          end
        end

        LOAD: begin
          if (in_pop) begin
            shift_r    <= in_data;
            byte_cnt_r <= '0;
            word_cnt_r <= word_cnt_r + 8'd1;
          end
        end

        PAYLOAD: begin
          if (handshake_s) begin
            acc_r      <= check_update(acc_r, head_byte_s);
            shift_r    <= shift_r << 8;
            byte_cnt_r <= byte_cnt_r + BCW'(1);
          end
        end

        CHECK: begin
          if (handshake_s) begin
            seq_r <= seq_r + 8'd1;
          end
        end

        default: begin
          // IDLE holds all datapath state.
        end
      endcase
    end
  end

endmodule
